img_byte_packer: RTL and testbench
==================================

IMG_BYTE_PACKER -- requirements
Module: img_byte_packer

Interface
REQ-001 Parameter LITTLE_ENDIAN, default 1, SHALL select lane order: 1 = first byte of a word in out_data[7:0]; 0 = first byte in out_data[31:24].
REQ-002 clock  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 reset  input  1  synchronous, active-low reset; reset==0 at a rising edge SHALL reset the block.
REQ-004 in_data  input  8  byte from the upstream source.
REQ-005 in_valid  input  1  in_data/in_last are valid this cycle.
REQ-006 in_last  input  1  byte ends the current frame; SHALL be ignored when in_valid==0.
REQ-007 upstream_stall  output  1  when 1, the offered byte SHALL NOT be accepted.
REQ-008 out_data  output  32  packed word to the 32-bit image model stage, registered.
REQ-009 out_valid  output  1  out_data/out_keep/out_last are valid, registered.
REQ-010 out_keep  output  4  per-lane valid mask (bit i = lane i after ordering), registered.
REQ-011 out_last  output  1  word carries the final byte of a frame, registered.
REQ-012 downstream_stall  input  1  consumer cannot take the output word this cycle.

Function
REQ-013 A byte SHALL be accepted in a cycle iff in_valid==1 and upstream_stall==0.
REQ-014 A 2-bit byte counter cnt (0..3) SHALL hold the number of bytes buffered in the partial word; cnt==0 is IDLE, 1..3 is ACCUM.
REQ-015 An accepted byte with cnt<3 and in_last==0 SHALL be written to lane cnt of the partial word, and cnt SHALL increment.
REQ-016 An accepted byte with cnt==3, or with in_last==1 at any cnt, SHALL complete the word: the word SHALL be loaded into the output register on that clock edge, and cnt SHALL return to 0.
REQ-017 Latency: out_valid SHALL rise in the cycle after the completing byte is accepted.
REQ-018 On completion, out_keep SHALL be set to the lanes filled (4'b1111 for a full word; cnt+1 low-order lanes for in_last), unused lanes of out_data SHALL be 0, and out_last SHALL equal in_last.
REQ-019 The output register SHALL be free when out_valid==0, or when out_valid==1 and downstream_stall==0 (drained this cycle).
REQ-020 upstream_stall SHALL be combinational: out_valid && downstream_stall && in_valid && (cnt==3 || in_last); non-completing bytes SHALL be accepted during an output stall.
REQ-021 When out_valid==1 and downstream_stall==1, out_data/out_keep/out_last/out_valid SHALL hold unchanged.
REQ-022 When the output drains and no word completes in the same cycle, out_valid SHALL go 0 on the next edge.
REQ-023 Simultaneous drain and completion SHALL load the new word with no bubble; out_valid SHALL stay 1.
REQ-024 A frame of N bytes SHALL produce ceil(N/4) words, with out_last set only on the final word.

Reset
REQ-025 Under reset: out_valid=0, out_last=0, out_keep=0, out_data=0, cnt=0, partial word=0.
REQ-026 Reset asserted mid-word or mid-stall SHALL discard the partial word and any held output word, with no output word emitted for them.
REQ-027 upstream_stall SHALL be 0 during reset and in the first cycle after reset.

Structure
REQ-028 BYTE_W=8, WORD_W=32, BYTES_PER_WORD=4, and the keep-mask typedef SHALL live in a shared package img_stream_pkg, used by this block and the image model stage.
REQ-029 No sub-module; counter, lane register and output register SHALL be in one module.

Verification
REQ-030 LITTLE_ENDIAN=1, bytes 11,22,33,44 on consecutive cycles, downstream_stall=0 -> one word 0x44332211, out_keep=1111, out_last=0, appearing the cycle after byte 44.
REQ-031 LITTLE_ENDIAN=0, same bytes -> out_data=0x11223344.
REQ-032 Frame AA,BB,CC,DD,EE (in_last on EE) -> word 0xDDCCBBAA keep=1111 last=0, then 0x000000EE keep=0001 last=1.
REQ-033 Output held with downstream_stall=1, then bytes 01,02,03,04 offered -> 01..03 accepted, 04 stalled (upstream_stall=1) and output word unchanged; release stall -> 04 accepted and word 0x04030201 follows.
REQ-034 Reset=0 after bytes 01,02 -> no output; then 05,06,07,08 -> 0x08070605 only.
REQ-035 Continuous 64-byte frame with random downstream_stall -> 16 words in order, no loss or duplication, out_last only on word 16.

Source files
------------

// File: rtl/img_stream_pkg.sv
// Shared stream definitions for the byte packer and the 32-bit image model stage.
package img_stream_pkg;

    localparam int BYTE_W         = 8;
    localparam int WORD_W         = 32;
    localparam int BYTES_PER_WORD = 4;
    localparam int CNT_W          = $clog2(BYTES_PER_WORD);

    typedef logic [BYTES_PER_WORD-1:0]             keep_t;
    typedef logic [BYTE_W-1:0]                     pix_byte_t;
    typedef logic [WORD_W-1:0]                     word_t;
    typedef logic [CNT_W-1:0]                      cnt_t;
    // lanes[i] is the i-th byte of a word in arrival order
    typedef logic [BYTES_PER_WORD-1:0][BYTE_W-1:0] lanes_t;

    typedef struct packed {
        word_t data;
        keep_t keep;
        logic  last;
    } out_word_t;

    // Mask with lanes 0..last_lane set (low-order lanes, arrival order).
    function automatic keep_t keep_upto(input cnt_t last_lane);
        keep_t k;
        k = '0;
        for (int i = 0; i < BYTES_PER_WORD; i++) begin
            if (i <= int'(last_lane)) k[i] = 1'b1;
        end
        return k;
    endfunction

    // Place arrival-ordered lanes into the output word.
    // little=1: first byte in [7:0]; little=0: first byte in [31:24].
    function automatic word_t order_lanes(input lanes_t lanes, input bit little);
        word_t w;
        w = '0;
        for (int i = 0; i < BYTES_PER_WORD; i++) begin
            if (little) w[i*BYTE_W +: BYTE_W] = lanes[i];
            else        w[(BYTES_PER_WORD-1-i)*BYTE_W +: BYTE_W] = lanes[i];
        end
        return w;
    endfunction

endpackage

// File: rtl/img_byte_packer_if.sv
// Byte-in / word-out stream bundle for img_byte_packer.
// slave = the packer itself, master = the surrounding source/sink.
interface img_byte_packer_if;
    import img_stream_pkg::*;

    pix_byte_t in_data;
    logic      in_valid;
    logic      in_last;
    logic      upstream_stall;

    word_t     out_data;
    logic      out_valid;
    keep_t     out_keep;
    logic      out_last;
    logic      downstream_stall;

    modport slave (
        input  in_data, in_valid, in_last, downstream_stall,
        output upstream_stall, out_data, out_valid, out_keep, out_last
    );

    modport master (
        output in_data, in_valid, in_last, downstream_stall,
        input  upstream_stall, out_data, out_valid, out_keep, out_last
    );

endinterface

// File: rtl/img_byte_packer.sv
// Packs an 8-bit byte stream into 32-bit words with keep mask and frame-last.
// cnt==0 is the idle state, 1..3 means a partial word is being accumulated.
module img_byte_packer
    import img_stream_pkg::*;
#(
    parameter bit LITTLE_ENDIAN = 1'b1
) (
    input  logic             clock,
    input  logic             reset,
    img_byte_packer_if.slave bus
);

    cnt_t      cnt,       cnt_nxt;
    lanes_t    part,      part_nxt;
    out_word_t out_q,     out_nxt;
    logic      out_vld_q, out_vld_nxt;

    logic      ends_word;
    logic      accept;
    logic      complete;
    lanes_t    done_lanes;

    // The offered byte would close the current word (full or frame end).
    assign ends_word = (cnt == cnt_t'(BYTES_PER_WORD-1)) || bus.in_last;

    // Only completing bytes need the output register, so only they stall.
    // Forced low during reset so nothing upstream waits on a word being discarded.
    assign bus.upstream_stall = reset && out_vld_q && bus.downstream_stall &&
                                bus.in_valid && ends_word;

    // Next-state: byte accumulation, word completion and output drain.
    always_comb begin
        cnt_nxt     = cnt;
        part_nxt    = part;
        out_nxt     = out_q;
        out_vld_nxt = out_vld_q;
        done_lanes  = part;

        accept   = bus.in_valid && !bus.upstream_stall;
        complete = accept && ends_word;

        // Drain without a new word -> bubble
        if (out_vld_q && !bus.downstream_stall) begin
            out_vld_nxt = 1'b0;
        end

        if (complete) begin
            // Lanes above cnt are still zero: the partial word is cleared on
            // every completion and on reset, and only lane cnt is ever written.
            done_lanes[cnt] = bus.in_data;
            out_nxt.data    = order_lanes(done_lanes, LITTLE_ENDIAN);
            // keep always counts lanes from bit 0 in arrival order
            out_nxt.keep    = keep_upto(cnt);
            out_nxt.last    = bus.in_last;
            out_vld_nxt     = 1'b1;
            cnt_nxt         = '0;
            part_nxt        = '0;
        end else if (accept) begin
            part_nxt[cnt] = bus.in_data;
            cnt_nxt       = cnt + 1'b1;
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!reset) begin
            cnt       <= '0;
            part      <= '0;
            out_q     <= '0;
            out_vld_q <= 1'b0;
        end else begin
            cnt       <= cnt_nxt;
            part      <= part_nxt;
            out_q     <= out_nxt;
            out_vld_q <= out_vld_nxt;
        end
    end

    assign bus.out_data  = out_q.data;
    assign bus.out_keep  = out_q.keep;
    assign bus.out_last  = out_q.last;
    assign bus.out_valid = out_vld_q;

endmodule

// File: tb/tb_img_byte_packer.sv
// Directed bench for img_byte_packer: a little- and a big-endian instance
// share one stimulus stream.
module tb_img_byte_packer;
    import img_stream_pkg::*;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] in_data = '0;
    logic       in_valid = 1'b0;
    logic       in_last = 1'b0;
    logic       downstream_stall = 1'b0;

    int checks = 0;
    int errs   = 0;

    img_byte_packer_if le_if ();
    img_byte_packer_if be_if ();

    assign le_if.in_data          = in_data;
    assign le_if.in_valid         = in_valid;
    assign le_if.in_last          = in_last;
    assign le_if.downstream_stall = downstream_stall;
    assign be_if.in_data          = in_data;
    assign be_if.in_valid         = in_valid;
    assign be_if.in_last          = in_last;
    assign be_if.downstream_stall = downstream_stall;

    img_byte_packer #(.LITTLE_ENDIAN(1'b1)) u_le (.clock(clock), .reset(reset), .bus(le_if.slave));
    img_byte_packer #(.LITTLE_ENDIAN(1'b0)) u_be (.clock(clock), .reset(reset), .bus(be_if.slave));

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic offer(input logic [7:0] b, input logic last);
        in_valid = 1'b1;
        in_data  = b;
        in_last  = last;
    endtask

    task automatic idle;
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_data  = '0;
    endtask

    task automatic send(input logic [7:0] b, input logic last);
        offer(b, last);
        tick();
    endtask

    word_t got_q[$];
    logic  got_last[$];

    initial begin
        int    b;
        int    cyc;
        bit    acc;
        word_t exp_w;

        // ---- reset state
        idle();
        tick(); tick();
        chk("rst_valid", le_if.out_valid, 0);
        chk("rst_keep",  le_if.out_keep, 0);
        chk("rst_data",  le_if.out_data, 0);
        chk("rst_last",  le_if.out_last, 0);
        chk("rst_ustall", le_if.upstream_stall, 0);
        reset = 1'b1;
        #1 chk("post_rst_ustall", le_if.upstream_stall, 0);

        // ---- four bytes -> one word, both lane orders
        send(8'h11, 0); send(8'h22, 0); send(8'h33, 0);
        chk("a_no_early_valid", le_if.out_valid, 0);
        send(8'h44, 0);
        chk("a_valid", le_if.out_valid, 1);
        chk("a_le_data", le_if.out_data, 32'h44332211);
        chk("a_keep", le_if.out_keep, 4'b1111);
        chk("a_last", le_if.out_last, 0);
        chk("a_be_data", be_if.out_data, 32'h11223344);
        idle(); tick();
        chk("a_drain_valid", le_if.out_valid, 0);

        // ---- five-byte frame: full word then one-byte tail
        send(8'hAA, 0); send(8'hBB, 0); send(8'hCC, 0); send(8'hDD, 0);
        chk("b_w0_data", le_if.out_data, 32'hDDCCBBAA);
        chk("b_w0_keep", le_if.out_keep, 4'b1111);
        chk("b_w0_last", le_if.out_last, 0);
        send(8'hEE, 1);
        chk("b_w1_valid", le_if.out_valid, 1);
        chk("b_w1_data", le_if.out_data, 32'h000000EE);
        chk("b_w1_keep", le_if.out_keep, 4'b0001);
        chk("b_w1_last", le_if.out_last, 1);
        chk("b_w1_be_data", be_if.out_data, 32'hEE000000);
        idle(); tick();
        chk("b_drain_valid", le_if.out_valid, 0);

        // ---- output stall: non-completing bytes pass, completing byte stalls
        downstream_stall = 1'b1;
        send(8'h10, 0); send(8'h20, 0); send(8'h30, 0); send(8'h40, 0);
        chk("c_held_data", le_if.out_data, 32'h40302010);
        offer(8'h01, 0); #1 chk("c_b01_ustall", le_if.upstream_stall, 0); tick();
        offer(8'h02, 0); #1 chk("c_b02_ustall", le_if.upstream_stall, 0); tick();
        offer(8'h03, 0); #1 chk("c_b03_ustall", le_if.upstream_stall, 0); tick();
        offer(8'h04, 0); #1 chk("c_b04_ustall", le_if.upstream_stall, 1);
        tick();
        chk("c_hold_data", le_if.out_data, 32'h40302010);
        chk("c_hold_valid", le_if.out_valid, 1);
        chk("c_hold_keep", le_if.out_keep, 4'b1111);
        chk("c_still_stall", le_if.upstream_stall, 1);
        downstream_stall = 1'b0;
        #1 chk("c_release_ustall", le_if.upstream_stall, 0);
        tick();
        chk("c_new_valid", le_if.out_valid, 1);
        chk("c_new_data", le_if.out_data, 32'h04030201);
        idle(); tick();
        chk("c_drain_valid", le_if.out_valid, 0);

        // ---- reset mid-stall and mid-word
        downstream_stall = 1'b1;
        send(8'h0A, 0); send(8'h0B, 0); send(8'h0C, 0); send(8'h0D, 0);
        offer(8'h01, 1);
        #1 chk("d_pre_rst_ustall", le_if.upstream_stall, 1);
        reset = 1'b0;
        #1 chk("d_in_rst_ustall", le_if.upstream_stall, 0);
        tick();
        chk("d_rst_valid", le_if.out_valid, 0);
        chk("d_rst_data", le_if.out_data, 0);
        chk("d_rst_keep", le_if.out_keep, 0);
        reset = 1'b1;
        idle();
        downstream_stall = 1'b0;
        tick();
        chk("d_after_rst_valid", le_if.out_valid, 0);
        send(8'h01, 0); send(8'h02, 0);
        reset = 1'b0; idle(); tick();
        reset = 1'b1; tick();
        chk("d_no_word", le_if.out_valid, 0);
        send(8'h05, 0); send(8'h06, 0);
        chk("d_no_stale_word", le_if.out_valid, 0);
        send(8'h07, 0);
        chk("d_b07_valid", le_if.out_valid, 0);
        send(8'h08, 0);
        chk("d_word_valid", le_if.out_valid, 1);
        chk("d_word_data", le_if.out_data, 32'h08070605);
        idle(); tick();
        chk("d_drain_valid", le_if.out_valid, 0);

        // ---- 64-byte frame with random output stalls
        b   = 1;
        cyc = 0;
        while (b <= 64 && cyc < 2000) begin
            downstream_stall = 1'($urandom_range(0, 1));
            offer(8'(b), b == 64);
            #1;
            if (le_if.out_valid && !downstream_stall) begin
                got_q.push_back(le_if.out_data);
                got_last.push_back(le_if.out_last);
            end
            acc = !le_if.upstream_stall;
            tick();
            cyc++;
            if (acc) b++;
        end
        chk("e_all_bytes_in", b, 65);
        idle();
        downstream_stall = 1'b0;
        repeat (4) begin
            #1;
            if (le_if.out_valid) begin
                got_q.push_back(le_if.out_data);
                got_last.push_back(le_if.out_last);
            end
            tick();
        end
        chk("e_word_count", got_q.size(), 16);
        for (int k = 0; k < 16 && k < got_q.size(); k++) begin
            exp_w = {8'(4*k+4), 8'(4*k+3), 8'(4*k+2), 8'(4*k+1)};
            chk($sformatf("e_w%0d_data", k), got_q[k], exp_w);
            chk($sformatf("e_w%0d_last", k), got_last[k], (k == 15) ? 1 : 0);
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
